axi4lite_arbiter: RTL and testbench

//  Shares one AXI4-Lite slave bus between N_MASTERS AXI4-Lite masters. One transaction (write or read) is in flight at a time.

---
 rtl/axi4lite_arbiter_pkg.sv | 9 +
 rtl/axi4lite_arbiter_if.sv | 26 ++
 rtl/axi4lite_arbiter_rr_arbiter.sv | 32 +++
 rtl/axi4lite_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_axi4lite_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4lite_arbiter_pkg.sv
// Shared types for the AXI4-Lite N:1 arbiter: FSM state encoding and response codes.
package axi4lite_pkg;

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA, ERR} state_t;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

endpackage

// File: rtl/axi4lite_arbiter_if.sv
// AXI4-Lite bundle for N ports; lane i of every vector belongs to port i.
interface axi4lite_arbiter_if #(
  parameter int N  = 1,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [N-1:0]         awvalid, awready, awprot;
  logic [N-1:0]         wvalid, wready, wstrb;
  logic [N-1:0]         bvalid, bready, bresp;
  logic [N-1:0]         arvalid, arready, arprot;
  logic [N-1:0]         rvalid, rready, rresp;
  logic [N-1:0][AW-1:0] awaddr, araddr;
  logic [N-1:0][DW-1:0] wdata, rdata;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4lite_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          valid
);

  logic [PW-1:0] j;

  // Scan from the farthest slot back toward ptr so the nearest requester wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = PW'((int'(ptr) + k) % N);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4lite_arbiter.sv
// Round-robin N:1 AXI4-Lite arbiter, one transaction in flight.
// Optional watchdog with error response: define AXI4LITE_ARB_TIMEOUT_EN.
module axi4lite_arbiter
  import axi4lite_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               rst,
  axi4lite_arbiter_if.slave  s_bus,
  axi4lite_arbiter_if.master m_bus
);

  localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  state_t                 state, state_n;
  logic [PW-1:0]          ptr, gidx, arb_idx;
  logic [N_MASTERS-1:0]   req, arb_gnt, gnt_oh;
  logic                   arb_vld, aw_done, w_done;
  logic                   aw_hs, w_hs, ar_hs;
  logic                   up_awready, up_wready, up_arready;
  logic                   up_bvalid, up_bresp, up_rvalid, up_rresp;
  logic [DATA_WIDTH-1:0]  up_rdata;
  logic [ADDR_WIDTH-1:0]  g_awaddr, g_araddr;

  assign req = s_bus.awvalid | s_bus.arvalid;

  rr_arbiter #(.N(N_MASTERS), .PW(PW)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_vld)
  );

  // Payload muxes are driven straight from the grant register.
  assign g_awaddr     = s_bus.awaddr[gidx];
  assign g_araddr     = s_bus.araddr[gidx];
  assign m_bus.awaddr = g_awaddr;
  assign m_bus.awprot = s_bus.awprot[gidx];
  assign m_bus.wdata  = s_bus.wdata[gidx];
  assign m_bus.wstrb  = s_bus.wstrb[gidx];
  assign m_bus.araddr = g_araddr;
  assign m_bus.arprot = s_bus.arprot[gidx];

  assign s_bus.awready = gnt_oh & {N_MASTERS{up_awready}};
  assign s_bus.wready  = gnt_oh & {N_MASTERS{up_wready}};
  assign s_bus.arready = gnt_oh & {N_MASTERS{up_arready}};
  assign s_bus.bvalid  = gnt_oh & {N_MASTERS{up_bvalid}};
  assign s_bus.bresp   = gnt_oh & {N_MASTERS{up_bresp}};
  assign s_bus.rvalid  = gnt_oh & {N_MASTERS{up_rvalid}};
  assign s_bus.rresp   = gnt_oh & {N_MASTERS{up_rresp}};
  assign s_bus.rdata   = {N_MASTERS{up_rdata}};

  assign aw_hs = up_awready & s_bus.awvalid[gidx];
  assign w_hs  = up_wready  & s_bus.wvalid[gidx];
  assign ar_hs = up_arready & s_bus.arvalid[gidx];

`ifdef AXI4LITE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          tmo, err_wr;

  assign tmo = (state inside {WR, WR_RESP, RD, RD_DATA}) && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cnt <= '0;
    else if (state == IDLE)          cnt <= '0;
    else if (!tmo && state != ERR)   cnt <= cnt + 1'b1;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_n       = state;
    m_bus.awvalid = 1'b0;
    m_bus.wvalid  = 1'b0;
    m_bus.bready  = 1'b0;
    m_bus.arvalid = 1'b0;
    m_bus.rready  = 1'b0;
    up_awready    = 1'b0;
    up_wready     = 1'b0;
    up_arready    = 1'b0;
    up_bvalid     = 1'b0;
    up_bresp      = RESP_OKAY;
    up_rvalid     = 1'b0;
    up_rresp      = RESP_OKAY;
    up_rdata      = '0;
`ifdef AXI4LITE_ARB_TIMEOUT_EN
    // Expiry cycle: everything dark for one cycle, then ERR answers the master.
    if (tmo) state_n = ERR;
    else
`endif
    case (state)
      IDLE: if (arb_vld) state_n = s_bus.awvalid[arb_idx] ? WR : RD;
      WR: begin
        m_bus.awvalid = !aw_done & s_bus.awvalid[gidx];
        m_bus.wvalid  = !w_done  & s_bus.wvalid[gidx];
        up_awready    = !aw_done & m_bus.awready[0];
        up_wready     = !w_done  & m_bus.wready[0];
        if ((aw_done | (m_bus.awready[0] & s_bus.awvalid[gidx])) &
            (w_done  | (m_bus.wready[0]  & s_bus.wvalid[gidx])))
          state_n = WR_RESP;
      end
      WR_RESP: begin
        m_bus.bready = s_bus.bready[gidx];
        up_bvalid    = m_bus.bvalid[0];
        up_bresp     = m_bus.bresp[0];
        if (m_bus.bvalid[0] & s_bus.bready[gidx]) state_n = IDLE;
      end
      RD: begin
        m_bus.arvalid = s_bus.arvalid[gidx];
        up_arready    = m_bus.arready[0];
        if (m_bus.arready[0] & s_bus.arvalid[gidx]) state_n = RD_DATA;
      end
      RD_DATA: begin
        m_bus.rready = s_bus.rready[gidx];
        up_rvalid    = m_bus.rvalid[0];
        up_rresp     = m_bus.rresp[0];
        up_rdata     = m_bus.rdata[0];
        if (m_bus.rvalid[0] & s_bus.rready[gidx]) state_n = IDLE;
      end
`ifdef AXI4LITE_ARB_TIMEOUT_EN
      ERR: begin
        if (!(aw_done & w_done)) begin
          up_awready = err_wr & !aw_done;
          up_wready  = err_wr & !w_done;
          up_arready = !err_wr & !aw_done;
        end else if (err_wr) begin
          up_bvalid = 1'b1;
          up_bresp  = RESP_ERR;
          if (s_bus.bready[gidx]) state_n = IDLE;
        end else begin
          up_rvalid = 1'b1;
          up_rresp  = RESP_ERR;
          if (s_bus.rready[gidx]) state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // aw_done doubles as "address accepted" for reads so ERR can reuse it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gidx    <= '0;
      gnt_oh  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
`ifdef AXI4LITE_ARB_TIMEOUT_EN
      err_wr  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (arb_vld) begin
          gidx   <= arb_idx;
          gnt_oh <= arb_gnt;
        end
      end else begin
        if (aw_hs | ar_hs) aw_done <= 1'b1;
        if (w_hs)          w_done  <= 1'b1;
        if (state_n == IDLE) begin
          ptr    <= (gidx == PW'(N_MASTERS - 1)) ? '0 : gidx + 1'b1;
          gnt_oh <= '0;
        end
      end
`ifdef AXI4LITE_ARB_TIMEOUT_EN
      if (tmo) begin
        err_wr <= state inside {WR, WR_RESP};
        if (state inside {RD, RD_DATA}) w_done <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi4lite_arbiter.sv
// Directed bench for axi4lite_arbiter with two masters; timeout scenario under AXI4LITE_ARB_TIMEOUT_EN.
module tb_axi4lite_arbiter;
  import axi4lite_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  axi4lite_arbiter_if #(.N(2), .AW(32), .DW(32)) s_if ();
  axi4lite_arbiter_if #(.N(1), .AW(32), .DW(32)) m_if ();

  axi4lite_arbiter #(
    .N_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s_bus (s_if),
    .m_bus (m_if)
  );

  task clear_bus();
    s_if.awvalid = '0; s_if.awaddr = '0; s_if.awprot = '0;
    s_if.wvalid  = '0; s_if.wdata  = '0; s_if.wstrb  = '0;
    s_if.bready  = '0; s_if.arvalid = '0; s_if.araddr = '0;
    s_if.arprot  = '0; s_if.rready  = '0;
    m_if.awready = '0; m_if.wready = '0; m_if.bvalid = '0; m_if.bresp = '0;
    m_if.arready = '0; m_if.rvalid = '0; m_if.rdata  = '0; m_if.rresp = '0;
  endtask

  task do_reset();
    rst = 1'b1;
    clear_bus();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task test_reset();
    rst = 1'b1;
    clear_bus();
    s_if.awvalid = 2'b11; s_if.arvalid = 2'b11; s_if.bready = 2'b11; s_if.rready = 2'b11;
    m_if.bvalid = 1'b1; m_if.rvalid = 1'b1; m_if.awready = 1'b1; m_if.arready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (dut.state !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE); else passed++;
    total++; if (dut.ptr !== 1'b0) $display("FAIL reset_ptr got=%0d exp=0", dut.ptr); else passed++;
    total++; if ({s_if.awready, s_if.wready, s_if.arready, s_if.bvalid, s_if.rvalid} !== 10'b0)
      $display("FAIL reset_s_side got=%b exp=0", {s_if.awready, s_if.wready, s_if.arready, s_if.bvalid, s_if.rvalid}); else passed++;
    total++; if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready} !== 5'b0)
      $display("FAIL reset_m_side got=%b exp=0", {m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready}); else passed++;
    clear_bus();
    rst = 1'b0;
  endtask

  task test_single_write();
    do_reset();
    s_if.awvalid = 2'b01; s_if.awaddr[0] = 32'h10; s_if.wvalid = 2'b01; s_if.wdata[0] = 32'hA5;
    s_if.wstrb = 2'b01; s_if.bready = 2'b01;
    m_if.awready = 1'b1; m_if.wready = 1'b1;
    @(negedge clk); #1;
    total++; if (m_if.awvalid !== 1'b1) $display("FAIL wr_awvalid_c1 got=%b exp=1", m_if.awvalid); else passed++;
    total++; if (m_if.awaddr !== 32'h10) $display("FAIL wr_awaddr got=%h exp=00000010", m_if.awaddr); else passed++;
    total++; if (m_if.wdata !== 32'hA5) $display("FAIL wr_wdata got=%h exp=000000a5", m_if.wdata); else passed++;
    total++; if (s_if.awready !== 2'b01) $display("FAIL wr_s_awready got=%b exp=01", s_if.awready); else passed++;
    @(negedge clk);
    s_if.awvalid = '0; s_if.wvalid = '0; #1;
    total++; if (s_if.bvalid !== 2'b00) $display("FAIL wr_bvalid_early got=%b exp=00", s_if.bvalid); else passed++;
    @(negedge clk);
    m_if.bvalid = 1'b1; m_if.bresp = 1'b0; #1;
    total++; if (s_if.bvalid !== 2'b01) $display("FAIL wr_s_bvalid got=%b exp=01", s_if.bvalid); else passed++;
    total++; if (s_if.bresp !== 2'b00) $display("FAIL wr_s_bresp got=%b exp=00", s_if.bresp); else passed++;
    total++; if (m_if.bready !== 1'b1) $display("FAIL wr_m_bready got=%b exp=1", m_if.bready); else passed++;
    @(negedge clk);
    m_if.bvalid = 1'b0; #1;
    total++; if (dut.ptr !== 1'b1) $display("FAIL wr_ptr_after got=%0d exp=1", dut.ptr); else passed++;
    total++; if (dut.state !== IDLE) $display("FAIL wr_idle_after got=%0d exp=%0d", dut.state, IDLE); else passed++;
  endtask

  task test_rr_reads();
    logic [31:0] d;
    logic [1:0]  exp_oh;
    int          g, n;
    do_reset();
    s_if.araddr[0] = 32'h100; s_if.araddr[1] = 32'h200;
    s_if.arvalid = 2'b11; s_if.rready = 2'b11;
    m_if.arready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      g = t % 2;
      d = 32'hD000_0000 + 32'(t);
      exp_oh = 2'b01 << g;
      n = 0;
      @(negedge clk); #1;
      while (m_if.arvalid !== 1'b1 && n < 4) begin @(negedge clk); #1; n++; end
      total++; if (m_if.arvalid !== 1'b1) $display("FAIL rr_arvalid_t%0d got=%b exp=1", t, m_if.arvalid); else passed++;
      total++; if (m_if.araddr !== (g == 1 ? 32'h200 : 32'h100))
        $display("FAIL rr_araddr_t%0d got=%h exp=%h", t, m_if.araddr, (g == 1 ? 32'h200 : 32'h100)); else passed++;
      total++; if (s_if.arready !== exp_oh) $display("FAIL rr_arready_t%0d got=%b exp=%b", t, s_if.arready, exp_oh); else passed++;
      @(negedge clk);
      m_if.rvalid = 1'b1; m_if.rdata = d; #1;
      total++; if (s_if.rvalid !== exp_oh) $display("FAIL rr_rvalid_t%0d got=%b exp=%b", t, s_if.rvalid, exp_oh); else passed++;
      total++; if (s_if.rdata[g] !== d) $display("FAIL rr_rdata_t%0d got=%h exp=%h", t, s_if.rdata[g], d); else passed++;
      @(negedge clk);
      m_if.rvalid = 1'b0;
    end
    clear_bus();
  endtask

  task test_aw_w_skew();
    int naw, nw;
    logic drop_aw, drop_w;
    do_reset();
    naw = 0; nw = 0; drop_aw = 1'b0; drop_w = 1'b0;
    s_if.awvalid = 2'b01; s_if.awaddr[0] = 32'h20; s_if.wvalid = 2'b01; s_if.wdata[0] = 32'h33;
    s_if.bready = 2'b01;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (drop_aw) s_if.awvalid = 2'b00;
      if (drop_w)  s_if.wvalid  = 2'b00;
      m_if.wready  = 1'b1;
      m_if.awready = (c >= 4);
      #1;
      if (m_if.awvalid === 1'b1 && m_if.awready === 1'b1) naw++;
      if (m_if.wvalid === 1'b1 && m_if.wready === 1'b1) nw++;
      if (s_if.awready[0] === 1'b1 && s_if.awvalid[0] === 1'b1) drop_aw = 1'b1;
      if (s_if.wready[0] === 1'b1 && s_if.wvalid[0] === 1'b1) drop_w = 1'b1;
      if (c == 3) begin
        total++; if (nw !== 1 || naw !== 0) $display("FAIL skew_mid got=aw%0d/w%0d exp=aw0/w1", naw, nw); else passed++;
        total++; if (m_if.awvalid !== 1'b1) $display("FAIL skew_aw_held got=%b exp=1", m_if.awvalid); else passed++;
      end
    end
    total++; if (naw !== 1) $display("FAIL skew_aw_count got=%0d exp=1", naw); else passed++;
    total++; if (nw !== 1) $display("FAIL skew_w_count got=%0d exp=1", nw); else passed++;
    total++; if (dut.state !== WR_RESP) $display("FAIL skew_state got=%0d exp=%0d", dut.state, WR_RESP); else passed++;
    @(negedge clk);
    m_if.bvalid = 1'b1; #1;
    total++; if (s_if.bvalid !== 2'b01) $display("FAIL skew_bvalid got=%b exp=01", s_if.bvalid); else passed++;
    @(negedge clk);
    m_if.bvalid = 1'b0;
    clear_bus();
  endtask

  task test_write_before_read();
    do_reset();
    s_if.awvalid = 2'b10; s_if.awaddr[1] = 32'h40; s_if.wvalid = 2'b10; s_if.wdata[1] = 32'h77;
    s_if.arvalid = 2'b10; s_if.araddr[1] = 32'h44; s_if.bready = 2'b10; s_if.rready = 2'b10;
    m_if.awready = 1'b1; m_if.wready = 1'b1;
    @(negedge clk); #1;
    total++; if (m_if.awvalid !== 1'b1) $display("FAIL wbr_awvalid got=%b exp=1", m_if.awvalid); else passed++;
    total++; if (m_if.arvalid !== 1'b0) $display("FAIL wbr_arvalid_first got=%b exp=0", m_if.arvalid); else passed++;
    total++; if (m_if.awaddr !== 32'h40) $display("FAIL wbr_awaddr got=%h exp=00000040", m_if.awaddr); else passed++;
    total++; if (s_if.awready !== 2'b10) $display("FAIL wbr_awready got=%b exp=10", s_if.awready); else passed++;
    @(negedge clk);
    s_if.awvalid = '0; s_if.wvalid = '0;
    m_if.bvalid = 1'b1; #1;
    total++; if (s_if.bvalid !== 2'b10) $display("FAIL wbr_bvalid got=%b exp=10", s_if.bvalid); else passed++;
    @(negedge clk);
    m_if.bvalid = 1'b0; #1;
    total++; if (dut.ptr !== 1'b0) $display("FAIL wbr_ptr_wrap got=%0d exp=0", dut.ptr); else passed++;
    @(negedge clk); #1;
    total++; if (m_if.arvalid !== 1'b1) $display("FAIL wbr_read_turn got=%b exp=1", m_if.arvalid); else passed++;
    total++; if (m_if.araddr !== 32'h44) $display("FAIL wbr_araddr got=%h exp=00000044", m_if.araddr); else passed++;
    total++; if (m_if.awvalid !== 1'b0) $display("FAIL wbr_no_second_aw got=%b exp=0", m_if.awvalid); else passed++;
    m_if.arready = 1'b1;
    @(negedge clk);
    s_if.arvalid = '0;
    m_if.rvalid = 1'b1; m_if.rdata = 32'h55; #1;
    total++; if (s_if.rvalid !== 2'b10 || s_if.rdata[1] !== 32'h55)
      $display("FAIL wbr_rdata got=%b/%h exp=10/00000055", s_if.rvalid, s_if.rdata[1]); else passed++;
    @(negedge clk);
    clear_bus();
  endtask

  task test_reset_mid_read();
    do_reset();
    s_if.arvalid = 2'b01; s_if.araddr[0] = 32'h8; s_if.rready = 2'b11; m_if.arready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    s_if.arvalid = 2'b00; m_if.rvalid = 1'b1;
    @(negedge clk);
    m_if.rvalid = 1'b0; s_if.arvalid = 2'b10; s_if.araddr[1] = 32'hC;
    @(negedge clk);
    @(negedge clk);
    s_if.arvalid = 2'b00; #1;
    total++; if (dut.state !== RD_DATA) $display("FAIL rst_mid_pre_state got=%0d exp=%0d", dut.state, RD_DATA); else passed++;
    total++; if (m_if.rready !== 1'b1) $display("FAIL rst_mid_pre_rready got=%b exp=1", m_if.rready); else passed++;
    rst = 1'b1; m_if.rvalid = 1'b1;
    @(negedge clk); #1;
    total++; if (m_if.rready !== 1'b0 || s_if.rvalid !== 2'b00)
      $display("FAIL rst_mid_outputs got=%b/%b exp=0/00", m_if.rready, s_if.rvalid); else passed++;
    total++; if (dut.state !== IDLE) $display("FAIL rst_mid_state got=%0d exp=%0d", dut.state, IDLE); else passed++;
    total++; if (dut.ptr !== 1'b0) $display("FAIL rst_mid_ptr got=%0d exp=0", dut.ptr); else passed++;
    clear_bus();
    rst = 1'b0;
  endtask

`ifdef AXI4LITE_ARB_TIMEOUT_EN
  task test_timeout();
    int n;
    do_reset();
    s_if.arvalid = 2'b01; s_if.araddr[0] = 32'hF0; s_if.rready = 2'b01; m_if.arready = 1'b0;
    for (int c = 1; c <= 15; c++) @(negedge clk);
    #1;
    total++; if (m_if.arvalid !== 1'b1) $display("FAIL tmo_arvalid_c15 got=%b exp=1", m_if.arvalid); else passed++;
    @(negedge clk); #1;
    total++; if (m_if.arvalid !== 1'b0) $display("FAIL tmo_arvalid_c16 got=%b exp=0", m_if.arvalid); else passed++;
    n = 0;
    while (s_if.arready[0] !== 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
    total++; if (s_if.arready[0] !== 1'b1) $display("FAIL tmo_err_arready got=%b exp=1", s_if.arready[0]); else passed++;
    @(negedge clk);
    s_if.arvalid = 2'b00; #1;
    n = 0;
    while (s_if.rvalid[0] !== 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
    total++; if (s_if.rvalid[0] !== 1'b1) $display("FAIL tmo_rvalid got=%b exp=1", s_if.rvalid[0]); else passed++;
    total++; if (s_if.rresp[0] !== 1'b1) $display("FAIL tmo_rresp got=%b exp=1", s_if.rresp[0]); else passed++;
    total++; if (s_if.rdata[0] !== 32'h0) $display("FAIL tmo_rdata got=%h exp=00000000", s_if.rdata[0]); else passed++;
    @(negedge clk); #1;
    total++; if (dut.state !== IDLE) $display("FAIL tmo_idle got=%0d exp=%0d", dut.state, IDLE); else passed++;
    clear_bus();
  endtask
`endif

  initial begin
    clear_bus();
    test_reset();
    test_single_write();
    test_rr_reads();
    test_aw_w_skew();
    test_write_before_read();
    test_reset_mid_read();
`ifdef AXI4LITE_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
